// File: rtl/sc_output_decoder.sv
// Stochastic-to-binary output stage: counts ones per stream over 2^L_W cycles, then argmax over N2 streams.
// Latency start->done is W+N2 cycles; start is ignored while busy, din only matters during accumulation.
module sc_output_decoder #(
    parameter int N2    = 4,
    parameter int L_W   = 8,
    parameter int IDX_W = $clog2(N2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N2-1:0]           din,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        class_idx,
    output logic [L_W:0]            max_count,
    output logic [N2*(L_W+1)-1:0]   counts
);

    localparam int CW = L_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [L_W-1:0]   r_win;
    logic [CW-1:0]    r_cnt [N2];
    logic [IDX_W-1:0] r_scan;
    logic [IDX_W-1:0] r_best_idx;
    logic [CW-1:0]    r_best;
    logic [IDX_W-1:0] r_cls;
    logic [CW-1:0]    r_max;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_win_last;
    logic             w_scan_last;
    logic             w_take;
    logic [CW-1:0]    w_cnt_k;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CW-1:0]    w_best_nxt;

    assign w_win_last  = (r_win == {L_W{1'b1}});
    assign w_scan_last = (r_scan == IDX_W'(N2 - 1));
    assign w_cnt_k     = r_cnt[r_scan];
    // Index 0 seeds the running best; later streams must beat it strictly so ties keep the lower index.
    assign w_take      = (r_scan == '0) || (w_cnt_k > r_best);
    assign w_idx_nxt   = w_take ? r_scan  : r_best_idx;
    assign w_best_nxt  = w_take ? w_cnt_k : r_best;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACCUM;
                    w_accept    = 1'b1;
                end
            end
            S_ACCUM: if (w_win_last)  w_state_nxt = S_SCAN;
            S_SCAN:  if (w_scan_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win      <= '0;
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best     <= '0;
            r_cls      <= '0;
            r_max      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < N2; i++) r_cnt[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_win  <= '0;
                        r_busy <= 1'b1;
                        for (int i = 0; i < N2; i++) r_cnt[i] <= '0;
                    end
                end
                S_ACCUM: begin
                    r_win <= r_win + 1'b1;
                    for (int i = 0; i < N2; i++) r_cnt[i] <= r_cnt[i] + CW'(din[i]);
                    if (w_win_last) r_scan <= '0;
                end
                S_SCAN: begin
                    r_scan     <= r_scan + 1'b1;
                    r_best_idx <= w_idx_nxt;
                    r_best     <= w_best_nxt;
                    if (w_scan_last) begin
                        r_cls  <= w_idx_nxt;
                        r_max  <= w_best_nxt;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N2; g++) begin : g_counts
            assign counts[g*CW +: CW] = r_cnt[g];
        end
    endgenerate

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_idx = r_cls;
    assign max_count = r_max;

endmodule
